sram_arbiter: RTL
=================

# sram_arbiter

Two-port Avalon-MM arbiter sharing the single SRAM controller command port between two requesters (port A, port B). It grants at most one command per cycle, registers the winning command onto the controller port, and tracks outstanding reads in an in-order tag FIFO so that each returned read word reaches the requester that issued it. It sits directly upstream of the SRAM controller; the controller accepts one command per cycle and returns read data in order.

## Interface
Parameters:
- ADDR_W, 20, word address width
- DATA_W, 16, data width
- BE_W, 2, byteenable width (DATA_W/8)
- MAX_PENDING, 4, outstanding-read tag FIFO depth; power of two, ≥2

Ports:
- clk  in  1  single clock, all logic rising-edge
- reset_n  in  1  asynchronous, active-low reset
- a_address / b_address  in  ADDR_W  requester word address
- a_byteenable / b_byteenable  in  BE_W  byte lanes
- a_read / b_read  in  1  read request
- a_write / b_write  in  1  write request
- a_writedata / b_writedata  in  DATA_W  write data
- a_waitrequest / b_waitrequest  out  1  command not accepted this cycle
- a_readdata / b_readdata  out  DATA_W  returned read data
- a_readdatavalid / b_readdatavalid  out  1  one-cycle pulse, readdata valid
- m_address  out  ADDR_W  to controller
- m_byteenable  out  BE_W  to controller
- m_read / m_write  out  1  one-cycle command strobes to controller
- m_writedata  out  DATA_W  to controller
- m_readdata  in  DATA_W  from controller
- m_readdatavalid  in  1  from controller

## Operation
- Request on a port = read | write. read & write together on one port: treated as read; write ignored.
- Grant (combinational, per cycle): one requesting port only → that port. Both → arbitration policy (see Configuration). None → idle.
- Read from the granted port is blocked when tag FIFO count == MAX_PENDING; in that case, the other port's write, if present, is granted instead.
- waitrequest_x = request_x & ~accepted_x. Both waitrequest outputs are forced to 1 while reset_n is low.
- Accepted command → registered onto m_* at the next edge; m_read/m_write are high for exactly one cycle per accepted command. m_address, m_byteenable, m_writedata hold their last value when idle.
- Accepted read pushes the owner tag (0 = A, 1 = B) into the tag FIFO.
- m_readdatavalid pops the FIFO head; m_readdata is registered to both x_readdata; x_readdatavalid pulses only for the tag owner.
- Push and pop in the same cycle: count unchanged. Full-check uses the pre-pop count; there is no combinational path from m_readdatavalid to waitrequest.
- m_readdatavalid with an empty FIFO: the data is dropped, no readdatavalid is raised, and the count stays at 0.
- Reset (asynchronous): m_read = m_write = 0, m_address/m_byteenable/m_writedata = 0, x_readdata = 0, x_readdatavalid = 0, FIFO emptied, round-robin pointer set to favour A. In-flight reads are abandoned and any later returns are dropped as orphans.

## Timing
- Command latency: accepted at edge N (waitrequest low in cycle N) → m_read/m_write high in cycle N+1.
- Read-return latency through arbiter: m_readdatavalid in cycle K → x_readdatavalid/x_readdata in cycle K+1.
- Throughput: one command per cycle total; back-to-back accepts from the same port are allowed.
- Requester inputs must be held stable while waitrequest is high (Avalon rule). The arbiter re-evaluates every cycle and does not lock a grant.

## Configuration
- SRAM_ARB_ROUND_ROBIN_EN defined: on contention, the port not granted most recently wins. The pointer updates only on an accepted command.
- Undefined: fixed priority, A always wins contention, and the pointer logic is absent. B is starved while A requests continuously.

## Test plan
- Single read A addr 0x00010: m_read in the next cycle with m_address=0x00010. Controller returns 0xBEEF → a_readdatavalid one cycle later with a_readdata=0xBEEF, and b_readdatavalid stays 0.
- A and B both hold writes for 4 cycles (round-robin build): grants alternate A,B,A,B. In the fixed-priority build: A,A,A,A and b_waitrequest stays 1.
- Interleaved reads A,B,A,B with returns 0x1111..0x4444 in order → readdatavalid pulses go to A,B,A,B carrying the matching data.
- MAX_PENDING=4 reads with no return → the 5th read sees waitrequest=1. A write from the other port is still accepted. One return lets the read be accepted on the following cycle.
- m_readdatavalid with an empty FIFO → no readdatavalid pulse on either port, and the count stays 0.
- Assert reset_n low with 2 reads pending → all outputs go to 0 and both waitrequests go to 1. After release, the two late returns are dropped, and a new read round-trips correctly.

Source files
------------

// File: rtl/sram_arbiter.sv
// sram_arbiter: two-port Avalon-MM arbiter sharing one SRAM controller command port, with an in-order read-tag FIFO.
// Define SRAM_ARB_ROUND_ROBIN_EN for round-robin contention; otherwise port A has fixed priority.
module sram_arbiter #(
   parameter int ADDR_W      = 20,
   parameter int DATA_W      = 16,
   parameter int BE_W        = 2,
   parameter int MAX_PENDING = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [ADDR_W-1:0] a_address,
   input  logic [BE_W-1:0]   a_byteenable,
   input  logic              a_read,
   input  logic              a_write,
   input  logic [DATA_W-1:0] a_writedata,
   output logic              a_waitrequest,
   output logic [DATA_W-1:0] a_readdata,
   output logic              a_readdatavalid,
   input  logic [ADDR_W-1:0] b_address,
   input  logic [BE_W-1:0]   b_byteenable,
   input  logic              b_read,
   input  logic              b_write,
   input  logic [DATA_W-1:0] b_writedata,
   output logic              b_waitrequest,
   output logic [DATA_W-1:0] b_readdata,
   output logic              b_readdatavalid,
   output logic [ADDR_W-1:0] m_address,
   output logic [BE_W-1:0]   m_byteenable,
   output logic              m_read,
   output logic              m_write,
   output logic [DATA_W-1:0] m_writedata,
   input  logic [DATA_W-1:0] m_readdata,
   input  logic              m_readdatavalid
);

   localparam int PTR_W = $clog2(MAX_PENDING);
   localparam int CNT_W = PTR_W + 1;

   logic             a_req, b_req;
   logic             full;
   logic             a_ok, b_ok;
   logic             grant_a, grant_b;
   logic             push, pop;
   logic             head_tag;
   logic [CNT_W-1:0] count;
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic             tag_mem [MAX_PENDING];

   assign a_req = a_read | a_write;
   assign b_req = b_read | b_write;

   // Full uses the registered count only, so m_readdatavalid never reaches waitrequest combinationally.
   assign full = (count == CNT_W'(MAX_PENDING));
   assign a_ok = a_req & ~(a_read & full);
   assign b_ok = b_req & ~(b_read & full);

`ifdef SRAM_ARB_ROUND_ROBIN_EN
   logic favor_b;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)     favor_b <= 1'b0;
      else if (grant_a) favor_b <= 1'b1;
      else if (grant_b) favor_b <= 1'b0;
   end

   assign grant_b = b_ok & (~a_ok | favor_b);
`else
   assign grant_b = b_ok & ~a_ok;
`endif
   assign grant_a = a_ok & ~grant_b;

   assign a_waitrequest = ~reset_n | (a_req & ~grant_a);
   assign b_waitrequest = ~reset_n | (b_req & ~grant_b);

   assign push     = (grant_a & a_read) | (grant_b & b_read);
   assign pop      = m_readdatavalid & (count != '0);
   assign head_tag = tag_mem[rd_ptr];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_read       <= 1'b0;
         m_write      <= 1'b0;
         m_address    <= '0;
         m_byteenable <= '0;
         m_writedata  <= '0;
      end else begin
         m_read  <= push;
         m_write <= (grant_a & a_write & ~a_read) | (grant_b & b_write & ~b_read);
         if (grant_a | grant_b) begin
            m_address    <= grant_b ? b_address    : a_address;
            m_byteenable <= grant_b ? b_byteenable : a_byteenable;
            m_writedata  <= grant_b ? b_writedata  : a_writedata;
         end
      end
   end

   // NOTE: tag storage has no reset; pointers and count alone define which entries are live.
   always_ff @(posedge clk) begin
      if (push) tag_mem[wr_ptr] <= grant_b;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         a_readdata      <= '0;
         b_readdata      <= '0;
         a_readdatavalid <= 1'b0;
         b_readdatavalid <= 1'b0;
      end else begin
         a_readdatavalid <= pop & ~head_tag;
         b_readdatavalid <= pop & head_tag;
         if (pop) begin
            a_readdata <= m_readdata;
            b_readdata <= m_readdata;
         end
      end
   end

endmodule
